// File: rtl/wb_master_bridge.sv
// Wishbone pipelined master bridge: turns single local read/write requests into
// one Wishbone cycle each, with stall, ack, error and timeout handling.
module wb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // Local initiator side
  input  logic        local_we,
  input  logic        local_oe,
  input  logic [23:0] local_address,
  input  logic [3:0]  local_byteSelect,
  input  logic [31:0] local_dataWrite,
  output logic [31:0] local_dataRead,
  output logic        local_busy,
  output logic        local_error,
  // Wishbone master side
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [23:0] wb_adr_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic        wb_error_i,
  input  logic [31:0] wb_data_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of bus cycles already spent, so the last
  // allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRequest, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [23:0]     adr_q, adr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            error_q, error_d;

  logic req;
  logic active;
  logic resp;
  logic timeout;
  logic fail;
  logic finish;

  // Completion qualifiers shared by next-state and datapath logic
  always_comb begin
    req     = local_we | local_oe;
    active  = (state_q == StRequest) || (state_q == StWait);
    resp    = wb_ack_i | wb_error_i;
    timeout = active && (cnt_q == CntLast);
    // Error beats ack; an ack in the timeout cycle still counts as success.
    fail    = wb_error_i | (timeout & ~wb_ack_i);
    finish  = active & (resp | timeout);
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StRequest;
      end
      StRequest: begin
        // Response or timeout completes even while stalled.
        if (resp || timeout) begin
          state_d = StDone;
        end else if (!wb_stall_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (resp || timeout) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state
  always_comb begin
    wb_cyc_o   = active;
    wb_stb_o   = (state_q == StRequest);
    local_busy = ((state_q == StIdle) & req) | active;
  end

  // Datapath next-state: request capture, timeout counter, completion data
  always_comb begin
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = active ? cnt_q + CntW'(1) : '0;
    error_d = finish & fail;
    if ((state_q == StIdle) && req) begin
      we_d    = local_we;
      sel_d   = local_byteSelect;
      adr_d   = local_address;
      wdata_d = local_dataWrite;
    end
    if (finish) begin
      if (fail) begin
        rdata_d = 32'hFFFF_FFFF;
      end else if (!we_q) begin
        rdata_d = wb_data_i;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= 32'hFFFF_FFFF;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign wb_we_o        = we_q;
  assign wb_sel_o       = sel_q;
  assign wb_adr_o       = adr_q;
  assign wb_data_o      = wdata_q;
  assign local_dataRead = rdata_q;
  assign local_error    = error_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: one default-timeout instance and one
// with TIMEOUT_CYCLES=4 sharing all inputs.
module tb_wb_master_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        local_we, local_oe;
  logic [23:0] local_address;
  logic [3:0]  local_byteSelect;
  logic [31:0] local_dataWrite;
  logic        wb_ack_i, wb_stall_i, wb_error_i;
  logic [31:0] wb_data_i;

  logic [31:0] local_dataRead, dread_t;
  logic        local_busy, busy_t, local_error, err_t;
  logic        wb_cyc_o, cyc_t, wb_stb_o, stb_t, wb_we_o, we_t;
  logic [3:0]  wb_sel_o, sel_t;
  logic [23:0] wb_adr_o, adr_t;
  logic [31:0] wb_data_o, wdat_t;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_master_bridge dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .local_we(local_we), .local_oe(local_oe), .local_address(local_address),
    .local_byteSelect(local_byteSelect), .local_dataWrite(local_dataWrite),
    .local_dataRead(local_dataRead), .local_busy(local_busy), .local_error(local_error),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_data_o(wb_data_o), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .wb_error_i(wb_error_i), .wb_data_i(wb_data_i)
  );

  wb_master_bridge #(.TIMEOUT_CYCLES(4)) dut_t (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .local_we(local_we), .local_oe(local_oe), .local_address(local_address),
    .local_byteSelect(local_byteSelect), .local_dataWrite(local_dataWrite),
    .local_dataRead(dread_t), .local_busy(busy_t), .local_error(err_t),
    .wb_cyc_o(cyc_t), .wb_stb_o(stb_t), .wb_we_o(we_t), .wb_sel_o(sel_t),
    .wb_adr_o(adr_t), .wb_data_o(wdat_t), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .wb_error_i(wb_error_i), .wb_data_i(wb_data_i)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge wb_clk_i);
  endtask

  task automatic do_reset();
    step();
    wb_rst_i = 1'b1; local_we = 1'b0; local_oe = 1'b0;
    local_address = '0; local_byteSelect = '0; local_dataWrite = '0;
    wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_error_i = 1'b0; wb_data_i = '0;
    step();
    wb_rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      errors++; $display("FAIL rst_ctl got cyc=%b stb=%b we=%b exp 0 0 0",
                         wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (wb_sel_o !== 4'h0 || wb_adr_o !== 24'h0 || wb_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_bus got sel=%h adr=%h dat=%h exp 0 0 0",
                         wb_sel_o, wb_adr_o, wb_data_o); end
    checks++; if (local_dataRead !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rst_dread got %h exp ffffffff", local_dataRead); end
    checks++; if (local_error !== 1'b0 || local_busy !== 1'b0) begin
      errors++; $display("FAIL rst_local got err=%b busy=%b exp 0 0", local_error, local_busy); end
  endtask

  task automatic test_zero_wait_read();
    step(); local_oe = 1'b1; local_address = 24'h000104; local_byteSelect = 4'hF;
    #1;
    checks++; if (local_busy !== 1'b1 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL zw_c0 got busy=%b cyc=%b exp 1 0", local_busy, wb_cyc_o); end
    step(); wb_ack_i = 1'b1; wb_data_i = 32'hDEADBEEF;
    #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b0) begin
      errors++; $display("FAIL zw_c1 got cyc=%b stb=%b we=%b exp 1 1 0",
                         wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (wb_adr_o !== 24'h000104) begin
      errors++; $display("FAIL zw_adr got %h exp 000104", wb_adr_o); end
    step(); wb_ack_i = 1'b0; wb_data_i = '0; local_oe = 1'b0;
    #1;
    checks++; if (local_dataRead !== 32'hDEADBEEF || local_busy !== 1'b0) begin
      errors++; $display("FAIL zw_c2 got dread=%h busy=%b exp deadbeef 0",
                         local_dataRead, local_busy); end
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || local_error !== 1'b0) begin
      errors++; $display("FAIL zw_c2ctl got cyc=%b stb=%b err=%b exp 0 0 0",
                         wb_cyc_o, wb_stb_o, local_error); end
    step(); #1;
    checks++; if (wb_cyc_o !== 1'b0 || local_busy !== 1'b0) begin
      errors++; $display("FAIL zw_c3 got cyc=%b busy=%b exp 0 0", wb_cyc_o, local_busy); end
  endtask

  task automatic test_stalled_write();
    step(); local_we = 1'b1; local_address = 24'h000200; local_byteSelect = 4'h3;
    local_dataWrite = 32'h12345678; wb_stall_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      wb_stall_i = (c <= 3);
      wb_ack_i   = (c == 6);
      #1;
      checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== (c <= 4)) begin
        errors++; $display("FAIL sw_c%0d got cyc=%b stb=%b exp 1 %b",
                           c, wb_cyc_o, wb_stb_o, (c <= 4)); end
      checks++; if (wb_data_o !== 32'h12345678 || wb_sel_o !== 4'h3 || wb_we_o !== 1'b1) begin
        errors++; $display("FAIL sw_bus%0d got dat=%h sel=%h we=%b exp 12345678 3 1",
                           c, wb_data_o, wb_sel_o, wb_we_o); end
    end
    step(); wb_ack_i = 1'b0; local_we = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || local_busy !== 1'b0 || local_error !== 1'b0) begin
      errors++; $display("FAIL sw_done got cyc=%b busy=%b err=%b exp 0 0 0",
                         wb_cyc_o, local_busy, local_error); end
    checks++; if (local_dataRead !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_dread got %h exp deadbeef", local_dataRead); end
  endtask

  task automatic test_bus_error();
    step(); local_oe = 1'b1; local_address = 24'h000300;
    step(); #1;
    checks++; if (wb_stb_o !== 1'b1) begin
      errors++; $display("FAIL be_stb got %b exp 1", wb_stb_o); end
    step(); wb_error_i = 1'b1; wb_data_i = 32'h55AA55AA;
    #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL be_wait got cyc=%b stb=%b exp 1 0", wb_cyc_o, wb_stb_o); end
    step(); wb_error_i = 1'b0; wb_data_i = '0; local_oe = 1'b0;
    #1;
    checks++; if (local_dataRead !== 32'hFFFF_FFFF || local_error !== 1'b1) begin
      errors++; $display("FAIL be_done got dread=%h err=%b exp ffffffff 1",
                         local_dataRead, local_error); end
    step(); #1;
    checks++; if (local_error !== 1'b0) begin
      errors++; $display("FAIL be_pulse got %b exp 0", local_error); end
  endtask

  task automatic test_timeout();
    do_reset();
    // Ack in the 4th bus cycle wins over the timeout.
    step(); local_oe = 1'b1; local_address = 24'h000400;
    for (int c = 1; c <= 4; c++) begin
      step();
      wb_ack_i  = (c == 4);
      wb_data_i = (c == 4) ? 32'hCAFEF00D : 32'h0;
      #1;
      checks++; if (cyc_t !== 1'b1) begin
        errors++; $display("FAIL to4_c%0d got cyc=%b exp 1", c, cyc_t); end
    end
    step(); wb_ack_i = 1'b0; wb_data_i = '0; local_oe = 1'b0;
    #1;
    checks++; if (cyc_t !== 1'b0 || err_t !== 1'b0 || dread_t !== 32'hCAFEF00D) begin
      errors++; $display("FAIL to4_done got cyc=%b err=%b dread=%h exp 0 0 cafef00d",
                         cyc_t, err_t, dread_t); end
    // No response at all: abort after 4 cycles.
    step(); local_oe = 1'b1; local_address = 24'h000404;
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      checks++; if (cyc_t !== 1'b1) begin
        errors++; $display("FAIL tonr_c%0d got cyc=%b exp 1", c, cyc_t); end
    end
    step(); local_oe = 1'b0;
    #1;
    checks++; if (cyc_t !== 1'b0 || stb_t !== 1'b0 || busy_t !== 1'b0) begin
      errors++; $display("FAIL tonr_drop got cyc=%b stb=%b busy=%b exp 0 0 0",
                         cyc_t, stb_t, busy_t); end
    checks++; if (err_t !== 1'b1 || dread_t !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL tonr_done got err=%b dread=%h exp 1 ffffffff", err_t, dread_t); end
    step(); #1;
    checks++; if (err_t !== 1'b0) begin
      errors++; $display("FAIL tonr_pulse got %b exp 0", err_t); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    step(); local_oe = 1'b1; local_address = 24'h000500;
    step();
    step(); #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      errors++; $display("FAIL rm_wait got cyc=%b stb=%b exp 1 0", wb_cyc_o, wb_stb_o); end
    local_oe = 1'b0; wb_rst_i = 1'b1;
    step(); wb_rst_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h77777777;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || local_busy !== 1'b0) begin
      errors++; $display("FAIL rm_rst got cyc=%b stb=%b busy=%b exp 0 0 0",
                         wb_cyc_o, wb_stb_o, local_busy); end
    step(); wb_ack_i = 1'b0; wb_data_i = '0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || local_error !== 1'b0 ||
                  local_dataRead !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rm_late got cyc=%b err=%b dread=%h exp 0 0 ffffffff",
                         wb_cyc_o, local_error, local_dataRead); end
    step(); local_oe = 1'b1; local_address = 24'h000104;
    step(); wb_ack_i = 1'b1; wb_data_i = 32'h0BADF00D;
    #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 24'h000104) begin
      errors++; $display("FAIL rm_next got cyc=%b adr=%h exp 1 000104", wb_cyc_o, wb_adr_o); end
    step(); wb_ack_i = 1'b0; wb_data_i = '0; local_oe = 1'b0;
    #1;
    checks++; if (local_dataRead !== 32'h0BADF00D || local_busy !== 1'b0) begin
      errors++; $display("FAIL rm_done got dread=%h busy=%b exp 0badf00d 0",
                         local_dataRead, local_busy); end
  endtask

  task automatic test_back_to_back();
    step(); local_we = 1'b1; local_oe = 1'b1; local_address = 24'h000600;
    local_dataWrite = 32'hA5A5A5A5; local_byteSelect = 4'hF;
    step(); wb_ack_i = 1'b1;
    #1;
    checks++; if (wb_we_o !== 1'b1 || wb_cyc_o !== 1'b1) begin
      errors++; $display("FAIL bb_we got we=%b cyc=%b exp 1 1", wb_we_o, wb_cyc_o); end
    step(); wb_ack_i = 1'b0;
    #1;
    checks++; if (local_busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL bb_done1 got busy=%b cyc=%b exp 0 0", local_busy, wb_cyc_o); end
    step(); #1;
    checks++; if (local_busy !== 1'b1 || wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL bb_idle got busy=%b cyc=%b exp 1 0", local_busy, wb_cyc_o); end
    step(); wb_ack_i = 1'b1;
    #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b1) begin
      errors++; $display("FAIL bb_req2 got cyc=%b stb=%b we=%b exp 1 1 1",
                         wb_cyc_o, wb_stb_o, wb_we_o); end
    step(); wb_ack_i = 1'b0; local_we = 1'b0; local_oe = 1'b0;
    #1;
    checks++; if (local_busy !== 1'b0 || local_dataRead !== 32'h0BADF00D) begin
      errors++; $display("FAIL bb_done2 got busy=%b dread=%h exp 0 0badf00d",
                         local_busy, local_dataRead); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_stalled_write();
    test_bus_error();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
